// File: rtl/reservation_station_if.sv
// Reservation station bus: decoder issue port, ALU/LSB result broadcasts,
// stall feedback and the dispatch port towards the ALU.
interface reservation_station_if #(
    parameter int unsigned ROB_IDX_W = 4,
    parameter int unsigned OP_W      = 6
);
    logic                 issue_rs_ready;
    logic [ROB_IDX_W-1:0] issue_rob_index;
    logic [OP_W-1:0]      issue_op;
    logic [31:0]          issue_rs1_val;
    logic [31:0]          issue_rs2_val;
    logic [ROB_IDX_W-1:0] issue_rs1_depend;
    logic [ROB_IDX_W-1:0] issue_rs2_depend;
    logic [31:0]          issue_imm;
    logic [31:0]          issue_PC;
    logic                 issue_pred_br;

    logic                 alu_ready;
    logic [ROB_IDX_W-1:0] alu_rob_index;
    logic [31:0]          alu_result;
    logic                 lsb_ready;
    logic [ROB_IDX_W-1:0] lsb_rob_index;
    logic [31:0]          lsb_result;

    logic                 rs_full;
    logic                 rs_to_alu_valid;
    logic [OP_W-1:0]      rs_to_alu_op;
    logic [31:0]          rs_to_alu_rs1;
    logic [31:0]          rs_to_alu_rs2;
    logic [31:0]          rs_to_alu_imm;
    logic [31:0]          rs_to_alu_PC;
    logic [ROB_IDX_W-1:0] rs_to_alu_rob_index;
    logic                 rs_to_alu_pred_br;

    modport master (
        output issue_rs_ready, issue_rob_index, issue_op, issue_rs1_val, issue_rs2_val,
               issue_rs1_depend, issue_rs2_depend, issue_imm, issue_PC, issue_pred_br,
               alu_ready, alu_rob_index, alu_result, lsb_ready, lsb_rob_index, lsb_result,
        input  rs_full, rs_to_alu_valid, rs_to_alu_op, rs_to_alu_rs1, rs_to_alu_rs2,
               rs_to_alu_imm, rs_to_alu_PC, rs_to_alu_rob_index, rs_to_alu_pred_br
    );

    modport slave (
        input  issue_rs_ready, issue_rob_index, issue_op, issue_rs1_val, issue_rs2_val,
               issue_rs1_depend, issue_rs2_depend, issue_imm, issue_PC, issue_pred_br,
               alu_ready, alu_rob_index, alu_result, lsb_ready, lsb_rob_index, lsb_result,
        output rs_full, rs_to_alu_valid, rs_to_alu_op, rs_to_alu_rs1, rs_to_alu_rs2,
               rs_to_alu_imm, rs_to_alu_PC, rs_to_alu_rob_index, rs_to_alu_pred_br
    );
endinterface

// File: rtl/reservation_station.sv
// Reservation station for ALU-class instructions: holds issued instructions
// until both operands are present, snoops ALU/LSB broadcasts for wakeup and
// dispatches the lowest-indexed ready entry each cycle.
module reservation_station #(
    parameter int unsigned RS_SIZE   = 16,
    parameter int unsigned ROB_IDX_W = 4,
    parameter int unsigned OP_W      = 6
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  clr_in,
    reservation_station_if.slave  bus
);
    localparam int unsigned IDX_W = $clog2(RS_SIZE);

    logic [RS_SIZE-1:0]   busy;
    logic [OP_W-1:0]      e_op   [RS_SIZE];
    logic [31:0]          e_v1   [RS_SIZE];
    logic [31:0]          e_v2   [RS_SIZE];
    logic [ROB_IDX_W-1:0] e_q1   [RS_SIZE];
    logic [ROB_IDX_W-1:0] e_q2   [RS_SIZE];
    logic [31:0]          e_imm  [RS_SIZE];
    logic [31:0]          e_pc   [RS_SIZE];
    logic [ROB_IDX_W-1:0] e_rob  [RS_SIZE];
    logic                 e_pred [RS_SIZE];

    logic [IDX_W-1:0] free_idx;
    logic             free_found;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_found;

    // Full depends on busy bits only, so a same-edge dispatch never unblocks the decoder combinationally.
    assign bus.rs_full = &busy;

    // Priority pick of the lowest free slot and the lowest ready slot.
    always_comb begin
        free_idx   = '0;
        free_found = 1'b0;
        sel_idx    = '0;
        sel_found  = 1'b0;
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            if (!busy[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (busy[i] && e_q1[i] == '0 && e_q2[i] == '0 && !sel_found) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    // Entry state: wakeup, dispatch and issue; issue writes come last so they override wakeup on that slot.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy                    <= '0;
            bus.rs_to_alu_valid     <= 1'b0;
            bus.rs_to_alu_op        <= '0;
            bus.rs_to_alu_rs1       <= '0;
            bus.rs_to_alu_rs2       <= '0;
            bus.rs_to_alu_imm       <= '0;
            bus.rs_to_alu_PC        <= '0;
            bus.rs_to_alu_rob_index <= '0;
            bus.rs_to_alu_pred_br   <= 1'b0;
        end else if (rdy_in) begin
            if (clr_in) begin
                busy                <= '0;
                bus.rs_to_alu_valid <= 1'b0;
            end else begin
                for (int unsigned i = 0; i < RS_SIZE; i++) begin
                    if (busy[i]) begin
                        if (e_q1[i] != '0) begin
                            if (bus.alu_ready && e_q1[i] == bus.alu_rob_index) begin
                                e_v1[i] <= bus.alu_result;
                                e_q1[i] <= '0;
                            end else if (bus.lsb_ready && e_q1[i] == bus.lsb_rob_index) begin
                                e_v1[i] <= bus.lsb_result;
                                e_q1[i] <= '0;
                            end
                        end
                        if (e_q2[i] != '0) begin
                            if (bus.alu_ready && e_q2[i] == bus.alu_rob_index) begin
                                e_v2[i] <= bus.alu_result;
                                e_q2[i] <= '0;
                            end else if (bus.lsb_ready && e_q2[i] == bus.lsb_rob_index) begin
                                e_v2[i] <= bus.lsb_result;
                                e_q2[i] <= '0;
                            end
                        end
                    end
                end

                if (sel_found) begin
                    bus.rs_to_alu_valid     <= 1'b1;
                    bus.rs_to_alu_op        <= e_op[sel_idx];
                    bus.rs_to_alu_rs1       <= e_v1[sel_idx];
                    bus.rs_to_alu_rs2       <= e_v2[sel_idx];
                    bus.rs_to_alu_imm       <= e_imm[sel_idx];
                    bus.rs_to_alu_PC        <= e_pc[sel_idx];
                    bus.rs_to_alu_rob_index <= e_rob[sel_idx];
                    bus.rs_to_alu_pred_br   <= e_pred[sel_idx];
                    busy[sel_idx]           <= 1'b0;
                end else begin
                    bus.rs_to_alu_valid <= 1'b0;
                end

                if (bus.issue_rs_ready && free_found) begin
                    busy[free_idx]   <= 1'b1;
                    e_op[free_idx]   <= bus.issue_op;
                    e_v1[free_idx]   <= bus.issue_rs1_val;
                    e_v2[free_idx]   <= bus.issue_rs2_val;
                    e_q1[free_idx]   <= bus.issue_rs1_depend;
                    e_q2[free_idx]   <= bus.issue_rs2_depend;
                    e_imm[free_idx]  <= bus.issue_imm;
                    e_pc[free_idx]   <= bus.issue_PC;
                    e_rob[free_idx]  <= bus.issue_rob_index;
                    e_pred[free_idx] <= bus.issue_pred_br;
                end
            end
        end
    end
endmodule

// File: tb/tb_reservation_station.sv
// Self-checking bench for reservation_station: directed scenarios plus
// randomized traffic compared cycle by cycle against a behavioural model.
module tb_reservation_station;
    logic clk_in = 1'b0;
    logic rst_in, rdy_in, clr_in;
    int   total = 0;
    int   bad   = 0;

    always #5 clk_in = ~clk_in;

    reservation_station_if #(.ROB_IDX_W(4), .OP_W(6)) bus ();

    reservation_station #(.RS_SIZE(16), .ROB_IDX_W(4), .OP_W(6)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .clr_in (clr_in),
        .bus    (bus.slave)
    );

    typedef struct {
        bit          busy;
        logic [5:0]  op;
        logic [31:0] v1, v2, imm, pc;
        logic [3:0]  q1, q2, rob;
        logic        pred;
    } ent_t;

    ent_t        m [16];
    bit          m_valid;
    logic [5:0]  m_op;
    logic [31:0] m_rs1, m_rs2, m_imm, m_pc;
    logic [3:0]  m_rob;
    logic        m_pred;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Operand wakeup value from a broadcast, ALU taking priority.
    function automatic bit snoop(input logic [3:0] q, output logic [31:0] v);
        v = '0;
        if (q == 4'd0) return 1'b0;
        if (bus.alu_ready && q == bus.alu_rob_index) begin v = bus.alu_result; return 1'b1; end
        if (bus.lsb_ready && q == bus.lsb_rob_index) begin v = bus.lsb_result; return 1'b1; end
        return 1'b0;
    endfunction

    // Model of one clock edge, using the inputs present at the edge.
    task automatic model_edge();
        ent_t        pre [16];
        int          sel, fr;
        logic [31:0] v;
        pre = m;
        if (rst_in) begin
            foreach (m[i]) m[i].busy = 1'b0;
            m_valid = 0; m_op = '0; m_rs1 = '0; m_rs2 = '0; m_imm = '0; m_pc = '0; m_rob = '0; m_pred = 1'b0;
            return;
        end
        if (!rdy_in) return;
        if (clr_in) begin
            foreach (m[i]) m[i].busy = 1'b0;
            m_valid = 0;
            return;
        end
        sel = -1; fr = -1;
        for (int i = 15; i >= 0; i--) begin
            if (pre[i].busy && pre[i].q1 == 0 && pre[i].q2 == 0) sel = i;
            if (!pre[i].busy) fr = i;
        end
        for (int i = 0; i < 16; i++) begin
            if (pre[i].busy) begin
                if (snoop(pre[i].q1, v)) begin m[i].v1 = v; m[i].q1 = 0; end
                if (snoop(pre[i].q2, v)) begin m[i].v2 = v; m[i].q2 = 0; end
            end
        end
        m_valid = (sel >= 0);
        if (sel >= 0) begin
            m_op = pre[sel].op; m_rs1 = pre[sel].v1; m_rs2 = pre[sel].v2; m_imm = pre[sel].imm;
            m_pc = pre[sel].pc; m_rob = pre[sel].rob; m_pred = pre[sel].pred;
            m[sel].busy = 1'b0;
        end
        if (bus.issue_rs_ready && fr >= 0) begin
            m[fr].busy = 1'b1;
            m[fr].op = bus.issue_op; m[fr].v1 = bus.issue_rs1_val; m[fr].v2 = bus.issue_rs2_val;
            m[fr].q1 = bus.issue_rs1_depend; m[fr].q2 = bus.issue_rs2_depend;
            m[fr].imm = bus.issue_imm; m[fr].pc = bus.issue_PC; m[fr].rob = bus.issue_rob_index;
            m[fr].pred = bus.issue_pred_br;
        end
    endtask

    function automatic bit model_full();
        foreach (m[i]) if (!m[i].busy) return 1'b0;
        return 1'b1;
    endfunction

    task automatic compare_all();
        check_eq("rs_full", 32'(bus.rs_full), 32'(model_full()));
        check_eq("valid",   32'(bus.rs_to_alu_valid), 32'(m_valid));
        check_eq("op",      32'(bus.rs_to_alu_op), 32'(m_op));
        check_eq("rs1",     bus.rs_to_alu_rs1, m_rs1);
        check_eq("rs2",     bus.rs_to_alu_rs2, m_rs2);
        check_eq("imm",     bus.rs_to_alu_imm, m_imm);
        check_eq("pc",      bus.rs_to_alu_PC, m_pc);
        check_eq("rob",     32'(bus.rs_to_alu_rob_index), 32'(m_rob));
        check_eq("pred",    32'(bus.rs_to_alu_pred_br), 32'(m_pred));
    endtask

    task automatic tick();
        @(posedge clk_in);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle();
        rst_in = 0; rdy_in = 1; clr_in = 0;
        bus.issue_rs_ready = 0; bus.issue_rob_index = '0; bus.issue_op = '0;
        bus.issue_rs1_val = '0; bus.issue_rs2_val = '0;
        bus.issue_rs1_depend = '0; bus.issue_rs2_depend = '0;
        bus.issue_imm = '0; bus.issue_PC = '0; bus.issue_pred_br = 0;
        bus.alu_ready = 0; bus.alu_rob_index = '0; bus.alu_result = '0;
        bus.lsb_ready = 0; bus.lsb_rob_index = '0; bus.lsb_result = '0;
    endtask

    task automatic put(input logic [3:0] rob, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] qa, input logic [3:0] qb);
        bus.issue_rs_ready = 1; bus.issue_rob_index = rob; bus.issue_op = op;
        bus.issue_rs1_val = a; bus.issue_rs2_val = b;
        bus.issue_rs1_depend = qa; bus.issue_rs2_depend = qb;
        bus.issue_imm = {28'h0, rob} + 32'h100; bus.issue_PC = {28'h0, rob} << 2; bus.issue_pred_br = rob[0];
    endtask

    task automatic drain();
        idle();
        for (int i = 0; i < 20; i++) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        foreach (m[i]) m[i] = '{default: '0};
        m_valid = 0; m_op = '0; m_rs1 = '0; m_rs2 = '0; m_imm = '0; m_pc = '0; m_rob = '0; m_pred = 0;

        idle(); rst_in = 1;
        tick(); tick();
        check_eq("reset_valid", 32'(bus.rs_to_alu_valid), 32'd0);
        check_eq("reset_full",  32'(bus.rs_full), 32'd0);
        check_eq("reset_rs1",   bus.rs_to_alu_rs1, 32'd0);

        // Ready ADD: dispatch visible after the second edge, for one cycle.
        idle(); put(4'd3, 6'd1, 32'd5, 32'd7, 4'd0, 4'd0); tick();
        check_eq("add_not_yet", 32'(bus.rs_to_alu_valid), 32'd0);
        idle(); tick();
        check_eq("add_valid", 32'(bus.rs_to_alu_valid), 32'd1);
        check_eq("add_rs1",   bus.rs_to_alu_rs1, 32'd5);
        check_eq("add_rs2",   bus.rs_to_alu_rs2, 32'd7);
        check_eq("add_rob",   32'(bus.rs_to_alu_rob_index), 32'd3);
        tick();
        check_eq("add_once",  32'(bus.rs_to_alu_valid), 32'd0);

        // Wakeup from the ALU.
        put(4'd2, 6'd2, 32'hdead, 32'd1, 4'd1, 4'd0); tick();
        idle(); tick();
        check_eq("sub_wait", 32'(bus.rs_to_alu_valid), 32'd0);
        bus.alu_ready = 1; bus.alu_rob_index = 4'd1; bus.alu_result = 32'h10; tick();
        check_eq("sub_wait2", 32'(bus.rs_to_alu_valid), 32'd0);
        idle(); tick();
        check_eq("sub_valid", 32'(bus.rs_to_alu_valid), 32'd1);
        check_eq("sub_rs1",   bus.rs_to_alu_rs1, 32'h10);

        // Both operands wake on the same edge from different buses.
        put(4'd5, 6'd3, 32'h0, 32'h0, 4'd4, 4'd6); tick();
        idle();
        bus.alu_ready = 1; bus.alu_rob_index = 4'd4; bus.alu_result = 32'hA;
        bus.lsb_ready = 1; bus.lsb_rob_index = 4'd6; bus.lsb_result = 32'hB;
        tick();
        idle(); tick();
        check_eq("dual_rs1", bus.rs_to_alu_rs1, 32'hA);
        check_eq("dual_rs2", bus.rs_to_alu_rs2, 32'hB);

        // Fill all 16 entries waiting on rob 9, then release them.
        for (int i = 0; i < 16; i++) begin
            put(4'(i), 6'(i), 32'(i), 32'(i * 3), 4'd9, 4'd0); tick();
        end
        check_eq("full_high", 32'(bus.rs_full), 32'd1);
        put(4'd15, 6'd9, 32'h55, 32'h66, 4'd0, 4'd0); tick();
        idle(); bus.alu_ready = 1; bus.alu_rob_index = 4'd9; bus.alu_result = 32'h99; tick();
        idle();
        for (int i = 0; i < 16; i++) begin
            tick();
            check_eq("order_rob", 32'(bus.rs_to_alu_rob_index), 32'(i));
        end
        drain();

        // Flush together with an issue.
        for (int i = 0; i < 5; i++) begin
            put(4'(i + 1), 6'd4, 32'd1, 32'd2, 4'd7, 4'd0); tick();
        end
        put(4'd8, 6'd4, 32'd1, 32'd2, 4'd0, 4'd0); clr_in = 1; tick();
        check_eq("clr_full",  32'(bus.rs_full), 32'd0);
        check_eq("clr_valid", 32'(bus.rs_to_alu_valid), 32'd0);
        idle(); bus.alu_ready = 1; bus.alu_rob_index = 4'd7; tick();
        idle(); tick(); tick();
        check_eq("clr_nodisp", 32'(bus.rs_to_alu_valid), 32'd0);

        // Stalled cycle must not capture a broadcast.
        put(4'd6, 6'd5, 32'd0, 32'd3, 4'd5, 4'd0); tick();
        idle(); rdy_in = 0; bus.alu_ready = 1; bus.alu_rob_index = 4'd5; bus.alu_result = 32'h77; tick();
        idle(); tick(); tick();
        check_eq("rdy_hold", 32'(bus.rs_to_alu_valid), 32'd0);
        bus.lsb_ready = 1; bus.lsb_rob_index = 4'd5; bus.lsb_result = 32'h88; tick();
        idle(); tick();
        check_eq("rdy_later", bus.rs_to_alu_rs1, 32'h88);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            idle();
            rdy_in = ($urandom_range(0, 9) != 0);
            clr_in = ($urandom_range(0, 49) == 0);
            rst_in = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 9) < 6)
                put(4'($urandom), 6'($urandom), $urandom, $urandom,
                    ($urandom_range(0, 1) != 0) ? 4'd0 : 4'($urandom_range(1, 15)),
                    ($urandom_range(0, 2) != 0) ? 4'd0 : 4'($urandom_range(1, 15)));
            bus.alu_ready = ($urandom_range(0, 2) == 0);
            bus.alu_rob_index = 4'($urandom); bus.alu_result = $urandom;
            bus.lsb_ready = ($urandom_range(0, 2) == 0);
            bus.lsb_rob_index = 4'($urandom); bus.lsb_result = $urandom;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/reservation_station.md
# reservation_station

Buffers ALU-class instructions (LUI, AUIPC, JAL, JALR, register/immediate arithmetic, branches) issued by the decoder until both source operands are available, then dispatches one ready instruction per cycle to the ALU. It sits directly downstream of the decoder's RS issue port and upstream of the ALU. It snoops the ALU and LSB result broadcasts to wake up waiting operands. It drives `rs_full` back to the decoder's stall logic.

## Interface
- `RS_SIZE`, 16: number of entries; power of two, ≥2.
- `ROB_IDX_W`, 4: ROB index width; index 0 means "no dependency / value present".
- `OP_W`, 6: operation-enum width.
- `clk_in` in 1: clock; all state updates on rising edge.
- `rst_in` in 1: reset; synchronous, active-high.
- `rdy_in` in 1: global enable; low freezes all state and outputs.
- `clr_in` in 1: misprediction flush; synchronous, active-high.
- `issue_rs_ready` in 1: decoder presents an instruction for this block.
- `issue_rob_index` in ROB_IDX_W: destination ROB entry.
- `issue_op` in OP_W: operation enum.
- `issue_rs1_val`, `issue_rs2_val` in 32 each: operand values; valid when the matching depend is 0.
- `issue_rs1_depend`, `issue_rs2_depend` in ROB_IDX_W each: producing ROB index; 0 means ready.
- `issue_imm`, `issue_PC` in 32 each: immediate and instruction PC.
- `issue_pred_br` in 1: predicted-taken flag.
- `alu_ready` in 1, `alu_rob_index` in ROB_IDX_W, `alu_result` in 32: ALU broadcast.
- `lsb_ready` in 1, `lsb_rob_index` in ROB_IDX_W, `lsb_result` in 32: LSB broadcast.
- `rs_full` out 1: no free entry in current state.
- `rs_to_alu_valid` out 1: dispatch strobe, one cycle per instruction.
- `rs_to_alu_op`, `rs_to_alu_rs1`, `rs_to_alu_rs2`, `rs_to_alu_imm`, `rs_to_alu_PC`, `rs_to_alu_rob_index`, `rs_to_alu_pred_br`: dispatched fields, registered.

## Operation
- Entry state: busy, op, v1, q1, v2, q2, imm, PC, rob_index, pred_br.
- Reset or `clr_in` at an edge clears every busy bit and `rs_to_alu_valid`. The issue input and dispatch in that cycle are discarded. Data fields are don't-care; data outputs reset to 0.
- `rdy_in` low: no state change, including wakeup, issue and dispatch. `rs_to_alu_valid` holds its value.
- Issue: when `issue_rs_ready` is high, the instruction is written into the lowest-indexed non-busy entry, which becomes busy.
  - Issue while `rs_full` is high is a protocol violation. The input is ignored and no entry is overwritten.
- Wakeup: at each edge, for every busy entry and each operand with q≠0:
  - q==`alu_rob_index` with `alu_ready` high: v←`alu_result`, q←0.
  - Otherwise q==`lsb_rob_index` with `lsb_ready` high: v←`lsb_result`, q←0.
  - Both operands of one entry may wake in the same edge, from the same or different buses.
- Wakeup does not apply to the entry being issued in the same edge. The decoder has already forwarded same-cycle broadcasts.
- Select: the lowest-indexed busy entry with q1==0 and q2==0, evaluated on current (pre-edge) state.
  - At the edge its fields load into the `rs_to_alu_*` registers, `rs_to_alu_valid`←1, and its busy bit clears.
  - If no entry is ready, `rs_to_alu_valid`←0.
- An entry woken at edge E is selectable in the cycle after E, not earlier.
- `rs_full` is combinational from the busy bits only: high iff all RS_SIZE entries are busy. An entry freed by dispatch counts as free only after the edge, which avoids a combinational loop through the decoder.

## Timing
- Issue to dispatch with ready operands: instruction sampled at edge E; `rs_to_alu_valid` high in the cycle after edge E+1.
- Wakeup to dispatch: broadcast sampled at edge E; dispatch visible after edge E+1.
- Throughput: one dispatch per cycle. Issue and dispatch in the same edge are allowed, including into/from the last free slot.
- `rs_full` rises the cycle after the edge that fills the last entry. It falls the cycle after the edge that frees any entry.
- Flush latency: one edge. Everything is empty and `rs_full` is low in the following cycle.

## Test plan
- Reset, then issue ADD rob=3, rs1=5, rs2=7, both depends 0 → after 2 edges `rs_to_alu_valid`=1, rs1=5, rs2=7, rob=3 for exactly one cycle.
- Issue SUB rob=2 with rs1_depend=1 → no dispatch. Then `alu_ready`=1, rob=1, result=0x10 → dispatch on the next edge with rs1=0x10.
- Issue an entry with q1=4, q2=6. Same-cycle `alu_ready` rob 4 (0xA) and `lsb_ready` rob 6 (0xB) → one edge later both captured; dispatched with rs1=0xA, rs2=0xB.
- Issue 16 instructions, each depending on rob 9 → `rs_full`=1. Broadcast rob 9 → dispatch in ascending entry order, one per cycle; `rs_full` falls after the first dispatch.
- Fill 5 entries, assert `clr_in` together with an issue → next cycle `rs_full`=0, `rs_to_alu_valid`=0, and no later dispatch occurs.
- Hold `rdy_in`=0 across a matching broadcast → the entry stays waiting; the broadcast is not captured.
